// File: rtl/lcrc_pkg.sv
// Shared definitions for the link-layer CRC checker.
// Holds the CRC-16 polynomial and initial value, field widths, the number of
// bit-serial CRC steps per frame, and the checker state encoding.
package lcrc_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'h0000;

  localparam int unsigned SEQ_W   = 12;
  localparam int unsigned TLP_W   = 96;
  localparam int unsigned CRC_W   = 16;
  localparam int unsigned FRAME_W = 128;

  // Bits covered by the CRC: sequence field plus TLP (frame_in[127:16]).
  localparam int unsigned CALC_BITS = 112;
  localparam int unsigned CNT_W     = $clog2(CALC_BITS + 1);
  localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(CALC_BITS);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CHECK,
    REPORT
  } state_t;

endpackage

// File: rtl/lcrc_serial.sv
// Bit-serial CRC-16 engine, MSB first, no final XOR.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   clear     - load CRC_INIT (has priority over shift_en)
//   shift_en  - advance the CRC by one message bit
//   data_in   - message bit for this step
//   crc       - current CRC register
module lcrc_serial
  import lcrc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             data_in,
  output logic [CRC_W-1:0] crc
);

  logic feedback;

  assign feedback = crc[CRC_W-1] ^ data_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (shift_en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/lcrc_checker.sv
// Link-layer receive checker: verifies the LCRC of a 128-bit frame bit-serially,
// classifies the sequence number against next_seq and reports ACK/NAK.
// Optional statistics build macro: LCRC_STATS_EN (adds crc_err_cnt/seq_err_cnt).
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   frame_in     - {4'b0, seq[11:0]}, TLP[95:0], LCRC[15:0]
//   frame_valid  - frame_in valid; accepted when frame_ready is high
//   frame_ready  - high only while idle
//   tlp_out      - payload of the last good frame
//   tlp_valid    - one-cycle pulse with a good frame
//   ack, nak     - one-cycle acknowledge pulses
//   ack_seq      - sequence number reported with ack/nak
//   crc_err_cnt, seq_err_cnt - saturating error counters (LCRC_STATS_EN only)
module lcrc_checker
  import lcrc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [TLP_W-1:0]   tlp_out,
  output logic               tlp_valid,
  output logic               ack,
  output logic               nak,
  output logic [SEQ_W-1:0]   ack_seq
`ifdef LCRC_STATS_EN
  ,
  output logic [15:0]        crc_err_cnt,
  output logic [15:0]        seq_err_cnt
`endif
);

  state_t               state;
  logic [FRAME_W-1:0]   frame_q;
  logic [CALC_BITS-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [SEQ_W-1:0]     next_seq;
  logic                 nak_sent;

  logic                 crc_clear;
  logic                 crc_shift;
  logic [CRC_W-1:0]     crc;
  logic                 crc_good;
  logic [SEQ_W-1:0]     seq;
  logic [SEQ_W-1:0]     prev_seq;

  assign crc_clear = frame_valid && frame_ready;
  // The counter reaches CALC_LAST after the final shift; that extra CALC
  // cycle lines REPORT up exactly 114 cycles after acceptance.
  assign crc_shift = (state == CALC) && (bit_cnt != CALC_LAST);

  assign seq      = frame_q[FRAME_W-5 -: SEQ_W];
  assign prev_seq = next_seq - 12'd1;
  assign crc_good = (crc == frame_q[CRC_W-1:0]) && (frame_q[FRAME_W-1 -: 4] == 4'b0);

  lcrc_serial u_serial (
    .clk      (clk),
    .rst      (rst),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .data_in  (shreg[CALC_BITS-1]),
    .crc      (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      frame_ready <= 1'b1;
      frame_q     <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      next_seq    <= '0;
      nak_sent    <= 1'b0;
      tlp_out     <= '0;
      tlp_valid   <= 1'b0;
      ack         <= 1'b0;
      nak         <= 1'b0;
      ack_seq     <= '0;
`ifdef LCRC_STATS_EN
      crc_err_cnt <= '0;
      seq_err_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (frame_valid) begin
            frame_q     <= frame_in;
            shreg       <= frame_in[FRAME_W-1:CRC_W];
            bit_cnt     <= '0;
            frame_ready <= 1'b0;
            state       <= CALC;
          end
        end

        CALC: begin
          if (bit_cnt == CALC_LAST) begin
            state <= CHECK;
          end else begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        CHECK: begin
          state <= REPORT;
          if (!crc_good) begin
`ifdef LCRC_STATS_EN
            if (crc_err_cnt != '1) crc_err_cnt <= crc_err_cnt + 16'd1;
`endif
            if (!nak_sent) begin
              nak      <= 1'b1;
              ack_seq  <= prev_seq;
              nak_sent <= 1'b1;
            end
          end else if (seq == next_seq) begin
            tlp_valid <= 1'b1;
            ack       <= 1'b1;
            ack_seq   <= seq;
            tlp_out   <= frame_q[FRAME_W-SEQ_W-5:CRC_W];
            next_seq  <= next_seq + 12'd1;
            nak_sent  <= 1'b0;
          end else if (seq == prev_seq) begin
            ack     <= 1'b1;
            ack_seq <= prev_seq;
          end else begin
`ifdef LCRC_STATS_EN
            if (seq_err_cnt != '1) seq_err_cnt <= seq_err_cnt + 16'd1;
`endif
            if (!nak_sent) begin
              nak      <= 1'b1;
              ack_seq  <= prev_seq;
              nak_sent <= 1'b1;
            end
          end
        end

        REPORT: begin
          tlp_valid   <= 1'b0;
          ack         <= 1'b0;
          nak         <= 1'b0;
          frame_ready <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state       <= IDLE;
          frame_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcrc_checker.sv
// Self-checking bench for lcrc_checker: directed scenarios plus randomized
// frames compared against a protocol-level reference model whose CRC is
// computed by polynomial long division.
module tb_lcrc_checker;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] frame_in;
  logic         frame_valid;
  logic         frame_ready;
  logic [95:0]  tlp_out;
  logic         tlp_valid;
  logic         ack;
  logic         nak;
  logic [11:0]  ack_seq;
`ifdef LCRC_STATS_EN
  logic [15:0]  crc_err_cnt;
  logic [15:0]  seq_err_cnt;
`endif

  always #5 clk = ~clk;

  lcrc_checker dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .tlp_out     (tlp_out),
    .tlp_valid   (tlp_valid),
    .ack         (ack),
    .nak         (nak),
    .ack_seq     (ack_seq)
`ifdef LCRC_STATS_EN
    ,
    .crc_err_cnt (crc_err_cnt),
    .seq_err_cnt (seq_err_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_next;
  bit          m_nak_sent;
  int          m_crc_err;
  int          m_seq_err;
  logic [95:0] m_tlp_out;

  bit          exp_pulse;
  logic        exp_tv, exp_ack, exp_nak;
  logic [11:0] exp_seq;

  // CRC with init 0 and no final XOR equals the remainder of M(x)*x^16 mod G(x).
  function automatic logic [15:0] model_crc(input logic [111:0] msg);
    logic [127:0] v;
    logic [127:0] g;
    v = {msg, 16'h0000};
    g = {111'b0, 17'h11021};
    for (int i = 127; i >= 16; i--)
      if (v[i]) v = v ^ (g << (i - 16));
    return v[15:0];
  endfunction

  function automatic logic [127:0] make_frame(input logic [3:0] nib, input logic [11:0] s,
                                              input logic [95:0] tlp, input logic [15:0] crc_xor);
    return {nib, s, tlp, model_crc({nib, s, tlp}) ^ crc_xor};
  endfunction

  task automatic model_reset();
    m_next = 0; m_nak_sent = 0; m_crc_err = 0; m_seq_err = 0; m_tlp_out = '0;
  endtask

  task automatic model_apply(input logic [127:0] f);
    int s, prev;
    bit good;
    s    = int'(f[123:112]);
    prev = (m_next + 4095) % 4096;
    good = (model_crc(f[127:16]) == f[15:0]) && (f[127:124] == 4'h0);
    exp_pulse = 0; exp_tv = 0; exp_ack = 0; exp_nak = 0; exp_seq = '0;
    if (!good) begin
      if (m_crc_err < 65535) m_crc_err++;
      if (!m_nak_sent) begin
        exp_pulse = 1; exp_nak = 1; exp_seq = 12'(prev); m_nak_sent = 1;
      end
    end else if (s == m_next) begin
      exp_pulse = 1; exp_tv = 1; exp_ack = 1; exp_seq = 12'(s);
      m_tlp_out = f[111:16];
      m_next = (m_next + 1) % 4096;
      m_nak_sent = 0;
    end else if (s == prev) begin
      exp_pulse = 1; exp_ack = 1; exp_seq = 12'(prev);
    end else begin
      if (m_seq_err < 65535) m_seq_err++;
      if (!m_nak_sent) begin
        exp_pulse = 1; exp_nak = 1; exp_seq = 12'(prev); m_nak_sent = 1;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int preload_bad = 0;

  task automatic run_frame(input logic [127:0] f, input bit scramble, input bit quiet, input int abort_at);
    int          wait_cnt, pulses, pk;
    bit          both, ready_end;
    logic        g_tv, g_ack, g_nak;
    logic [11:0] g_seq;
    pulses = 0; pk = 0; both = 0; ready_end = 0;
    g_tv = 0; g_ack = 0; g_nak = 0; g_seq = '0;
    wait_cnt = 0;
    do begin
      @(negedge clk);
      wait_cnt++;
    end while (!frame_ready && wait_cnt < 300);
    if (!frame_ready) begin
      check("ready_timeout", 128'(frame_ready), 128'(1));
      return;
    end
    if (abort_at == 0) model_apply(f);
    frame_in    = f;
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!scramble) frame_valid = 1'b0;
    for (int k = 1; k <= 115; k++) begin
      @(posedge clk);
      #1;
      if (abort_at != 0 && k == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_ready", 128'(frame_ready), 128'(1));
      end
      if (abort_at != 0 && k == abort_at + 2) rst = 1'b0;
      if (scramble) begin
        if (k < 100) frame_in = {$urandom, $urandom, $urandom, $urandom};
        else frame_valid = 1'b0;
      end
      if (ack || nak || tlp_valid) begin
        pulses++;
        if (pk == 0) begin
          pk = k; g_tv = tlp_valid; g_ack = ack; g_nak = nak; g_seq = ack_seq;
        end
      end
      if (ack && nak) both = 1;
      if (k == 115) ready_end = frame_ready;
    end
    if (abort_at != 0) begin
      check("abort_no_pulse", 128'(pulses), 128'(0));
      model_reset();
    end else if (quiet) begin
      if (pulses != 1 || pk != 114 || !g_ack || !g_tv || g_nak || g_seq != exp_seq)
        preload_bad++;
    end else begin
      check("pulse_count", 128'(pulses), 128'(exp_pulse ? 1 : 0));
      if (exp_pulse) begin
        check("latency", 128'(pk), 128'(114));
        check("tlp_valid", 128'(g_tv), 128'(exp_tv));
        check("ack", 128'(g_ack), 128'(exp_ack));
        check("nak", 128'(g_nak), 128'(exp_nak));
        check("ack_seq", 128'(g_seq), 128'(exp_seq));
      end
      check("ack_nak_excl", 128'(both), 128'(0));
      check("tlp_out", 128'(tlp_out), 128'(m_tlp_out));
      check("ready_after", 128'(ready_end), 128'(1));
`ifdef LCRC_STATS_EN
      check("crc_err_cnt", 128'(crc_err_cnt), 128'(m_crc_err));
      check("seq_err_cnt", 128'(seq_err_cnt), 128'(m_seq_err));
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [95:0] tlp0;
    logic [95:0] r_tlp;
    int          t, prev;
    rst = 1'b1; frame_valid = 1'b0; frame_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(frame_ready), 128'(1));
    check("rst_tlp_valid", 128'(tlp_valid), 128'(0));
    check("rst_ack", 128'(ack), 128'(0));
    check("rst_nak", 128'(nak), 128'(0));
    check("rst_ack_seq", 128'(ack_seq), 128'(0));
    check("rst_tlp_out", 128'(tlp_out), 128'(0));
`ifdef LCRC_STATS_EN
    check("rst_crc_err", 128'(crc_err_cnt), 128'(0));
    check("rst_seq_err", 128'(seq_err_cnt), 128'(0));
`endif
    @(negedge clk);
    rst = 1'b0;

    // good seq 0, bad LCRC seq 1, suppressed bad seq 2, good seq 1, duplicate seq 1
    tlp0 = 96'h0123456789ABCDEF012345AB;
    run_frame(make_frame(4'h0, 12'h000, tlp0, 16'h0000), 0, 0, 0);
    run_frame(make_frame(4'h0, 12'h001, tlp0 ^ 96'h5, 16'h0001), 0, 0, 0);
    run_frame(make_frame(4'h0, 12'h002, tlp0 ^ 96'h9, 16'h8000), 0, 0, 0);
    run_frame(make_frame(4'h0, 12'h001, tlp0 ^ 96'h7, 16'h0000), 0, 0, 0);
    run_frame(make_frame(4'h0, 12'h001, tlp0 ^ 96'h7, 16'h0000), 0, 0, 0);

    // randomized mix of good, duplicate, out-of-order, bad-CRC and malformed frames
    for (int n = 0; n < 24; n++) begin
      t     = $urandom_range(0, 4);
      r_tlp = {$urandom, $urandom, $urandom};
      prev  = (m_next + 4095) % 4096;
      case (t)
        0: run_frame(make_frame(4'h0, 12'(m_next), r_tlp, 16'h0), $urandom_range(0, 1) == 1, 0, 0);
        1: run_frame(make_frame(4'h0, 12'(prev), r_tlp, 16'h0), $urandom_range(0, 1) == 1, 0, 0);
        2: run_frame(make_frame(4'h0, 12'($urandom), r_tlp, 16'h0), $urandom_range(0, 1) == 1, 0, 0);
        3: run_frame(make_frame(4'h0, 12'(m_next), r_tlp, 16'($urandom_range(1, 65535))),
                     $urandom_range(0, 1) == 1, 0, 0);
        default: run_frame(make_frame(4'($urandom_range(1, 15)), 12'(m_next), r_tlp, 16'h0),
                           $urandom_range(0, 1) == 1, 0, 0);
      endcase
    end

    // abort mid-CALC by reset, then a good seq 0
    run_frame(make_frame(4'h0, 12'(m_next), tlp0, 16'h0), 0, 0, 50);
    run_frame(make_frame(4'h0, 12'h000, tlp0, 16'h0), 0, 0, 0);

    // malformed seq field with otherwise good CRC, input scrambled during CALC
    run_frame(make_frame(4'h1, 12'h000, tlp0, 16'h0), 1, 0, 0);
    run_frame(make_frame(4'h0, 12'h001, ~tlp0, 16'h0), 1, 0, 0);

    // sequence wrap: preload next_seq to 0xFFF with 4095 good frames
    do_reset();
    for (int n = 0; n < 4095; n++)
      run_frame(make_frame(4'h0, 12'(n), {$urandom, $urandom, $urandom}, 16'h0), 0, 1, 0);
    check("preload_acks", 128'(preload_bad), 128'(0));
    run_frame(make_frame(4'h0, 12'hFFF, tlp0, 16'h0), 0, 0, 0);
    run_frame(make_frame(4'h0, 12'h000, ~tlp0, 16'h0), 0, 0, 0);
    run_frame(make_frame(4'h0, 12'h005, tlp0, 16'h0), 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcrc_checker.md
LCRC_CHECKER -- requirements
Module: lcrc_checker

Interface
REQ-001 SHALL have clock and reset ports `clk` and `rst`: one clock, `clk`; reset `rst` is asynchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 frame_in  input  128  received frame: [127:112] seq field {4'b0, seq[11:0]}, [111:16] TLP, [15:0] LCRC.
REQ-005 frame_valid  input  1  frame_in valid.
REQ-006 frame_ready  output  1  checker can accept a frame.
REQ-007 tlp_out  output  96  TLP payload of an accepted good frame.
REQ-008 tlp_valid  output  1  one-cycle pulse; tlp_out valid.
REQ-009 ack  output  1  one-cycle ACK pulse.
REQ-010 nak  output  1  one-cycle NAK pulse.
REQ-011 ack_seq  output  12  sequence number reported with ack or nak.

Function
REQ-012 Frame acceptance SHALL occur on a rising edge where frame_valid && frame_ready; frame_ready SHALL be 1 only in IDLE.
REQ-013 State machine SHALL have four states:
  - IDLE -> CALC on accept.
  - CALC -> CHECK after 112 bit-steps.
  - CHECK -> REPORT unconditionally.
  - REPORT -> IDLE unconditionally.
REQ-014 CRC SHALL be CRC-16:
  - polynomial 0x1021, init 0x0000, no final XOR.
  - MSB-first over frame_in[127:16], one bit per CALC cycle.
REQ-015 A frame SHALL be "CRC good" iff the computed CRC equals frame_in[15:0] and frame_in[127:124] == 4'b0.
REQ-016 next_seq, a 12-bit counter with reset value 0, SHALL wrap from 0xFFF to 0x000.
REQ-017 Classification SHALL be made in CHECK:
  - CRC bad -> NAK.
  - seq == next_seq -> good.
  - seq == next_seq-1 (mod 4096) -> duplicate.
  - otherwise -> NAK.
REQ-018 Good frame: in REPORT, tlp_valid=1, ack=1, ack_seq=seq; next_seq increments; nak_sent clears.
REQ-019 Duplicate frame: in REPORT, ack=1, ack_seq=next_seq-1; tlp_valid=0; next_seq unchanged.
REQ-020 NAK case, nak_sent==0: in REPORT, nak=1, ack_seq=next_seq-1; nak_sent sets.
REQ-021 NAK case, nak_sent==1: no ack or nak pulse; frame dropped silently.
REQ-022 Latency: REPORT outputs SHALL appear exactly 114 cycles after the acceptance edge and last one cycle.
REQ-023 tlp_valid, ack and nak SHALL be 0 outside REPORT; ack and nak SHALL never both be 1.
REQ-024 frame_valid during CALC, CHECK or REPORT SHALL be ignored; the sender holds it.
REQ-025 frame_in SHALL be captured at acceptance; later changes SHALL NOT affect the result.

Reset
REQ-026 rst SHALL force the following values immediately:
  - state=IDLE, frame_ready=1.
  - tlp_valid=0, ack=0, nak=0, ack_seq=0, tlp_out=0.
  - next_seq=0, nak_sent=0, bit counter=0.
REQ-027 rst during CALC, CHECK or REPORT SHALL abort the frame with no pulse emitted.

Configuration
REQ-028 With LCRC_STATS_EN defined, outputs crc_err_cnt[15:0] and seq_err_cnt[15:0] SHALL exist.
REQ-029 Counter behaviour with LCRC_STATS_EN defined:
  - each counter SHALL saturate at 0xFFFF and reset to 0.
  - crc_err_cnt SHALL increment per CRC-bad frame.
  - seq_err_cnt SHALL increment per out-of-order, non-duplicate frame.
  - both SHALL increment regardless of NAK suppression.
REQ-030 Without LCRC_STATS_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package lcrc_pkg SHALL hold:
  - CRC polynomial and init constants.
  - field widths (SEQ 12, TLP 96, CRC 16, FRAME 128).
  - CALC bit count 112.
  - state enum.
REQ-032 Sub-module lcrc_serial SHALL implement the bit-serial CRC-16 engine (clear, shift-enable, data bit in, crc out); lcrc_checker owns the FSM and sequence logic.

Verification
REQ-033 After reset, send a frame with seq 0, TLP 0x0123..AB and the correct model CRC -> at accept+114: tlp_valid=1, ack=1, ack_seq=0x000, tlp_out matches; next_seq=1.
REQ-034 Send seq 1 with LCRC bit 0 flipped -> nak=1, ack_seq=0x000. Then send seq 2 with a bad CRC -> no pulse (suppressed). With LCRC_STATS_EN, crc_err_cnt=2.
REQ-035 After REQ-034, send a good seq 1 -> ack=1, ack_seq=0x001. Then resend seq 1 -> duplicate: ack=1, ack_seq=0x001, tlp_valid=0.
REQ-036 Preload next_seq=0xFFF via 4095 good frames; send seq 0xFFF then seq 0x000 -> two ACKs with ack_seq 0xFFF, 0x000 (wrap). Send seq 0x005 -> nak, ack_seq=0x000.
REQ-037 Assert rst at cycle 50 of CALC -> no pulse, frame_ready=1 next cycle. Then a good frame with seq 0 -> ack_seq=0x000.
REQ-038 Send a good-CRC frame with seq field 0x1000 -> nak=1 (malformed); frame_in changed during CALC -> result unaffected.
